seg_frame_driver: RTL and testbench

Display-side counterpart to the anode strobe counter: drives a multiplexed, active-low common-anode 7-segment display. It accepts a packed hex word over a valid/ready handshake and double-buffers it so the value changes only at frame boundaries. It rotates one anode per slot, with a blanking interval at the start of every slot to suppress ghosting, and decodes each nibble to cathode patterns. It sits between the FPU result path and the board display pins.

---
 rtl/seg_frame_driver_pkg.sv | 9 +
 rtl/seg_frame_driver_if.sv | 8 +
 rtl/seg_frame_driver_hex_to_seg.sv | 9 +
 rtl/seg_frame_driver.sv | 83 ++++++++
 tb/tb_seg_frame_driver.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/seg_frame_driver_pkg.sv
// seg_frame_driver_pkg: shared constants, hex segment table and slot state type
package seg_frame_driver_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  typedef enum logic {ST_BLANK, ST_DRIVE} slot_t;
endpackage

// File: rtl/seg_frame_driver_if.sv
// seg_frame_driver_if: valid/ready hex word channel into the display driver
interface seg_frame_driver_if #(parameter int DIGITS = 4);
  logic [4*DIGITS-1:0] data_in;
  logic data_valid;
  logic data_ready;
  modport master (output data_in, data_valid, input data_ready);
  modport slave (input data_in, data_valid, output data_ready);
endinterface

// File: rtl/seg_frame_driver_hex_to_seg.sv
// hex_to_seg: nibble to active-low gfedcba cathode pattern
module hex_to_seg
  import seg_frame_driver_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  assign seg_o = HEX_SEG[nib_i];
endmodule

// File: rtl/seg_frame_driver.sv
// seg_frame_driver: double-buffered multiplexed common-anode 7-segment driver
module seg_frame_driver
  import seg_frame_driver_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int PHASE_BITS = 5,
  parameter int BLANK      = 4
) (
  input  logic                clk,
  input  logic                reset,
  seg_frame_driver_if.slave   bus,
  output logic [DIGITS-1:0]   an,
  output logic [6:0]          seg,
  output logic                frame_done
);
  localparam int IW = $clog2(DIGITS);
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);
  localparam logic [PHASE_BITS-1:0] DRIVE_TOP = PHASE_BITS'((1 << PHASE_BITS) - 1 - BLANK);

  logic [PHASE_BITS-1:0] phase_q, phase_d;
  logic [IW-1:0]         idx_q, idx_d;
  slot_t                 state_q, state_d;
  logic [4*DIGITS-1:0]   pend_q, pend_d, shown_q, shown_d;
  logic                  full_q, full_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic [6:0]            seg_q, seg_d, dec;
  logic                  done_q;
  logic                  wrap, boundary, accept;
  logic [3:0]            nib;

  assign nib = 4'(shown_q >> {idx_q, 2'b00});

  hex_to_seg u_dec (.nib_i(nib), .seg_o(dec));

  // slot timing and display outputs: blank the first BLANK cycles of each slot
  always_comb begin
    wrap     = phase_q == '0;
    boundary = wrap && idx_q == LAST;
    phase_d  = phase_q - 1'b1;
    idx_d    = wrap ? (idx_q == LAST ? '0 : idx_q + 1'b1) : idx_q;
    state_d  = phase_d > DRIVE_TOP ? ST_BLANK : ST_DRIVE;
    an_d     = state_q == ST_DRIVE ? ~(DIGITS'(1) << idx_q) : '1;
    seg_d    = state_q == ST_DRIVE ? dec : SEG_BLANK;
  end

  // double buffer: the boundary only sees a word that was pending before this edge
  always_comb begin
    accept  = bus.data_valid && !full_q;
    pend_d  = accept ? bus.data_in : pend_q;
    shown_d = boundary && full_q ? pend_q : shown_q;
    full_d  = boundary && full_q ? 1'b0 : (accept | full_q);
  end

  // state registers; reset blanks the display at once and drops any pending word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= '1;
      idx_q   <= '0;
      state_q <= ST_BLANK;
      an_q    <= '1;
      seg_q   <= SEG_BLANK;
      done_q  <= 1'b0;
      full_q  <= 1'b0;
      pend_q  <= '0;
      shown_q <= '0;
    end else begin
      phase_q <= phase_d;
      idx_q   <= idx_d;
      state_q <= state_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      done_q  <= boundary;
      full_q  <= full_d;
      pend_q  <= pend_d;
      shown_q <= shown_d;
    end
  end

  assign bus.data_ready = ~full_q;
  assign an             = an_q;
  assign seg            = seg_q;
  assign frame_done     = done_q;
endmodule

// File: tb/tb_seg_frame_driver.sv
// tb_seg_frame_driver: scoreboard bench for the multiplexed 7-segment driver
module tb_seg_frame_driver;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] an;
  logic [6:0] seg;
  logic frame_done;

  seg_frame_driver_if #(.DIGITS(4)) bus();

  seg_frame_driver #(.DIGITS(4), .PHASE_BITS(5), .BLANK(4)) dut (
    .clk(clk), .reset(reset), .bus(bus), .an(an), .seg(seg), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {int frame; logic [15:0] word;} exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int frame_cnt = 0;
  logic [6:0] rec [4];

  function automatic logic [6:0] hex7(logic [3:0] n);
    case (n)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(int frame, logic [15:0] word);
    exp_t e;
    e.frame = frame;
    e.word = word;
    q.push_back(e);
  endtask

  always @(posedge clk or posedge reset) cyc <= reset ? 0 : cyc + 1;

  task automatic at_edge(int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(int e, logic [15:0] w, int show);
    at_edge(e - 1);
    check("ready_before_accept", 32'(bus.data_ready), 1);
    bus.data_in = w;
    bus.data_valid = 1'b1;
    if (show > 0) push(show, w);
    at_edge(e);
    bus.data_valid = 1'b0;
    check("ready_after_accept", 32'(bus.data_ready), 0);
  endtask

  // monitor: per-cycle anode/blank checks, per-frame digit comparison against the queue
  always @(negedge clk) begin
    if (reset) begin
      frame_cnt = 0;
      foreach (rec[d]) rec[d] = 'x;
    end else begin
      check("anode_one_low", 32'((an == 4'hF) || $onehot(~an)), 1);
      if (an == 4'hF) check("blank_seg", 32'(seg), 32'h7F);
      for (int d = 0; d < 4; d++) if (!an[d]) rec[d] = seg;
      if (frame_done) begin
        frame_cnt++;
        while (q.size() > 0 && q[0].frame == frame_cnt) begin
          exp_t e;
          e = q.pop_front();
          for (int d = 0; d < 4; d++)
            check($sformatf("frame%0d_digit%0d", frame_cnt, d), 32'(rec[d]), 32'(hex7(e.word[4*d +: 4])));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    bus.data_valid = 1'b0;
    bus.data_in = '0;
    repeat (5) @(posedge clk);
    #1;
    check("reset_an", 32'(an), 32'hF);
    check("reset_seg", 32'(seg), 32'h7F);
    check("reset_ready", 32'(bus.data_ready), 1);
    check("reset_done", 32'(frame_done), 0);
    @(negedge clk);
    reset = 1'b0;
    push(1, 16'h0000);
    fork
      for (int e = 1; e <= 33; e++) begin
        at_edge(e);
        check("first_slot_an", 32'(an), (e < 5 || e == 33) ? 32'hF : 32'hE);
        check("first_slot_seg", 32'(seg), (e < 5 || e == 33) ? 32'h7F : 32'h40);
      end
      send(10, 16'h1234, 2);
    join
    at_edge(127);
    check("done_before_boundary", 32'(frame_done), 0);
    at_edge(128);
    check("first_frame_done", 32'(frame_done), 1);
    check("ready_after_copy", 32'(bus.data_ready), 1);
    at_edge(129);
    check("done_one_cycle", 32'(frame_done), 0);
    at_edge(139);
    bus.data_in = 16'hAAAA;
    bus.data_valid = 1'b1;
    push(3, 16'hAAAA);
    at_edge(140);
    check("first_b2b_accept", 32'(bus.data_ready), 0);
    bus.data_in = 16'h5555;
    push(4, 16'h5555);
    push(5, 16'h5555);
    at_edge(200);
    check("hold_ready_low", 32'(bus.data_ready), 0);
    at_edge(256);
    check("ready_after_boundary", 32'(bus.data_ready), 1);
    at_edge(257);
    check("second_b2b_accept", 32'(bus.data_ready), 0);
    bus.data_valid = 1'b0;
    send(512, 16'hFFFF, 6);
    check("accept_on_boundary_done", 32'(frame_done), 1);
    push(7, 16'hFFFF);
    for (int k = 0; k < 16; k++) begin
      logic [3:0] n;
      n = 4'(k);
      send(128 * (6 + k) + 10, {n, n, n, n}, 8 + k);
    end
    send(2955, 16'h9999, 0);
    at_edge(3029);
    check("digit2_drive_an", 32'(an), 32'hB);
    check("digit2_drive_seg", 32'(seg), 32'h0E);
    reset = 1'b1;
    #1;
    check("async_reset_an", 32'(an), 32'hF);
    check("async_reset_seg", 32'(seg), 32'h7F);
    check("async_reset_ready", 32'(bus.data_ready), 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    push(1, 16'h0000);
    push(2, 16'h0000);
    at_edge(5);
    check("post_reset_an", 32'(an), 32'hE);
    check("post_reset_seg", 32'(seg), 32'h40);
    at_edge(257);
    check("queue_drained", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
